// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb
//  Brief    : Multi-port register file with two write ports, NRD combinational
//             read ports, optional write-to-read forwarding and a per-register
//             busy scoreboard with registered pending-count.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG),
  localparam int CW      = $clog2(NREG + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       wa0,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd0,
  input  logic [XLEN-1:0]     wd1,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  output logic [CW-1:0]       busy_cnt
);

  // An address is writable/issuable when it names an existing register that
  // is not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [CW-1:0]   busy_cnt_q;
  logic [CW-1:0]   busy_cnt_d;

  // Qualified write/issue strobes. Gating with rst keeps the forwarding path
  // from leaking write data onto rdata while the file is held in reset.
  logic w0_ok;
  logic w1_ok;
  logic iss_ok;

  assign w0_ok  = !rst && we0    && addr_ok(wa0);
  assign w1_ok  = !rst && we1    && addr_ok(wa1);
  assign iss_ok = !rst && iss_en && addr_ok(iss_addr);

  // Next register/busy state: port 1 overrides port 0, an issue overrides a
  // write's busy-clear on the same register.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (w0_ok) begin
      regs_d[wa0] = wd0;
      busy_d[wa0] = 1'b0;
    end
    if (w1_ok) begin
      regs_d[wa1] = wd1;
      busy_d[wa1] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[iss_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  // Pending count follows the busy vector that will be held after the edge.
  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            readable;
    logic            wr0_hit;
    logic            wr1_hit;
    logic            iss_hit;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr     = ra[k*AW +: AW];
    assign readable = (int'(addr) < NREG) && !((ZERO_REG != 0) && (addr == '0));
    assign wr0_hit  = (BYPASS != 0) && w0_ok && (wa0 == addr);
    assign wr1_hit  = (BYPASS != 0) && w1_ok && (wa1 == addr);
    assign iss_hit  = iss_ok && (iss_addr == addr);

    // Stored value and busy flag, overridden by a same-cycle write when
    // forwarding is enabled (port 1 data wins; an issue keeps it busy).
    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (readable) begin
        data = regs_q[addr];
        bsy  = busy_q[addr];
      end
      if (wr1_hit) begin
        data = wd1;
      end else if (wr0_hit) begin
        data = wd0;
      end
      if ((wr0_hit || wr1_hit) && !iss_hit) begin
        bsy = 1'b0;
      end
    end

    assign rdata[k*XLEN +: XLEN] = data;
    assign rbusy[k]              = bsy;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_sb
//  Brief    : Scoreboard bench for reg_file_sb driving three builds in
//             parallel (default, no forwarding, 24 registers).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;
  localparam int XLEN = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;
  localparam int NCFG = 3;

  logic clk = 1'b0;
  logic rst;
  logic we0, we1;
  logic [AW-1:0] wa0, wa1;
  logic [XLEN-1:0] wd0, wd1;
  logic iss_en;
  logic [AW-1:0] iss_addr;
  logic [NRD*AW-1:0] ra;

  logic [NRD*XLEN-1:0] rd_a, rd_b, rd_c;
  logic [NRD-1:0] rb_a, rb_b, rb_c;
  logic [5:0] cnt_a, cnt_b;
  logic [4:0] cnt_c;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .iss_en(iss_en), .iss_addr(iss_addr), .ra(ra),
    .rdata(rd_a), .rbusy(rb_a), .busy_cnt(cnt_a));

  reg_file_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .iss_en(iss_en), .iss_addr(iss_addr), .ra(ra),
    .rdata(rd_b), .rbusy(rb_b), .busy_cnt(cnt_b));

  reg_file_sb #(.XLEN(32), .NREG(24), .NRD(2), .BYPASS(1), .ZERO_REG(1)) dut_c (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .iss_en(iss_en), .iss_addr(iss_addr), .ra(ra),
    .rdata(rd_c), .rbusy(rb_c), .busy_cnt(cnt_c));

  logic [NCFG-1:0][NRD-1:0][XLEN-1:0] act_rd;
  logic [NCFG-1:0][NRD-1:0]           act_rb;
  logic [NCFG-1:0][5:0]               act_cnt;
  assign act_rd  = {rd_c, rd_b, rd_a};
  assign act_rb  = {rb_c, rb_b, rb_a};
  assign act_cnt = {{1'b0, cnt_c}, cnt_b, cnt_a};

  typedef struct packed {
    logic [NCFG-1:0][NRD-1:0][XLEN-1:0] rd;
    logic [NCFG-1:0][NRD-1:0]           rb;
    logic [NCFG-1:0][5:0]               cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // Reference state: register contents and pending flags per build.
  logic [XLEN-1:0] mem [NCFG][32];
  bit              pend [NCFG][32];

  function automatic int nreg_of(input int c);
    return (c == 2) ? 24 : 32;
  endfunction

  function automatic bit byp_of(input int c);
    return (c != 1);
  endfunction

  function automatic bit ok(input int c, input int a);
    return (a < nreg_of(c)) && (a != 0);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCFG; c++)
      for (int a = 0; a < 32; a++) begin
        mem[c][a]  = '0;
        pend[c][a] = 1'b0;
      end
  endtask

  // Apply one cycle of stimulus, queue the outputs the file must show during
  // that cycle, then advance the reference across the rising edge.
  task automatic drive(input bit r,
                       input bit w0, input int a0, input logic [31:0] d0,
                       input bit w1, input int a1, input logic [31:0] d1,
                       input bit ie, input int ia,
                       input int r0, input int r1);
    exp_t e;
    rst = r; we0 = w0; wa0 = a0[AW-1:0]; wd0 = d0;
    we1 = w1; wa1 = a1[AW-1:0]; wd1 = d1;
    iss_en = ie; iss_addr = ia[AW-1:0];
    ra = {r1[AW-1:0], r0[AW-1:0]};
    if (r) model_reset();
    e = '0;
    for (int c = 0; c < NCFG; c++) begin
      int n = 0;
      for (int k = 0; k < NRD; k++) begin
        int rk = (k == 0) ? r0 : r1;
        logic [31:0] v = '0;
        bit b = 1'b0;
        bit h0, h1;
        if (ok(c, rk)) begin
          v = mem[c][rk];
          b = pend[c][rk];
        end
        h1 = !r && byp_of(c) && w1 && ok(c, a1) && (a1 == rk);
        h0 = !r && byp_of(c) && w0 && ok(c, a0) && (a0 == rk);
        if (h1) v = d1;
        else if (h0) v = d0;
        if ((h0 || h1) && !(ie && ok(c, ia) && (ia == rk))) b = 1'b0;
        e.rd[c][k] = v;
        e.rb[c][k] = b;
      end
      for (int a = 0; a < 32; a++) n += pend[c][a];
      e.cnt[c] = 6'(n);
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (!r) begin
      for (int c = 0; c < NCFG; c++) begin
        if (w0 && ok(c, a0)) begin mem[c][a0] = d0; pend[c][a0] = 1'b0; end
        if (w1 && ok(c, a1)) begin mem[c][a1] = d1; pend[c][a1] = 1'b0; end
        if (ie && ok(c, ia)) pend[c][ia] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input int r0, input int r1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  // Monitor: the file presents a result every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int c = 0; c < NCFG; c++) begin
        for (int k = 0; k < NRD; k++) begin
          checks++;
          if (act_rd[c][k] !== mon_e.rd[c][k]) begin
            errors++;
            $display("FAIL rdata cfg%0d port%0d t=%0t: got %h expected %h",
                     c, k, $time, act_rd[c][k], mon_e.rd[c][k]);
          end
          checks++;
          if (act_rb[c][k] !== mon_e.rb[c][k]) begin
            errors++;
            $display("FAIL rbusy cfg%0d port%0d t=%0t: got %b expected %b",
                     c, k, $time, act_rb[c][k], mon_e.rb[c][k]);
          end
        end
        checks++;
        if (act_cnt[c] !== mon_e.cnt[c]) begin
          errors++;
          $display("FAIL busy_cnt cfg%0d t=%0t: got %0d expected %0d",
                   c, $time, act_cnt[c], mon_e.cnt[c]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; we0 = 0; we1 = 0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    iss_en = 0; iss_addr = '0; ra = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset state, and writes/issues ignored while held in reset.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    drive(1, 1, 5, 32'h1234_5678, 1, 6, 32'h5555, 1, 6, 5, 6);

    // Basic write then read back, register 0 reads zero.
    drive(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 5, 0);
    idle(5, 0);

    // Same-address dual write: port 1 wins, also on the forwarding path.
    drive(0, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 7);
    idle(7, 7);

    // Register 0 is immune to writes and issues.
    drive(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0);

    // Scoreboard: issue 3 and 9, retire 3, then issue+write 9 together.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 9);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 3, 9);
    idle(3, 9);
    drive(0, 1, 3, 32'h3333, 0, 0, 0, 0, 0, 3, 9);
    idle(3, 9);
    drive(0, 0, 0, 0, 1, 9, 32'h9999, 1, 9, 9, 9);
    idle(9, 3);

    // Same-cycle write and read of 12: forwarded or old value per build.
    drive(0, 1, 12, 32'hA5, 0, 0, 0, 0, 0, 12, 12);
    idle(12, 0);

    // Load, issue, then asynchronous reset between edges.
    drive(0, 1, 1, 32'hCAFE_0001, 1, 2, 32'hCAFE_0002, 1, 4, 1, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 4, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    drive(1, 1, 1, 32'h7777, 0, 0, 0, 1, 4, 1, 4);
    idle(1, 4);

    // Address 30 exists only in the 32-entry builds.
    drive(0, 1, 30, 32'h3030_3030, 0, 0, 0, 1, 30, 30, 30);
    idle(30, 29);

    // Randomized traffic, including occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0),
            $urandom_range(0, 1), $urandom_range(0, 31), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 31), $urandom,
            ($urandom_range(0, 2) == 0), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31));
    end

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
